// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator car controller and its request scanner.
// Holds direction codes, door/motion levels, the controller state enum and
// the hall-call bit index helper used to decode the 14-bit hall bus.
package elevator_pkg;

   // Hardware ceiling for served floors; the floor bus is 3 bits wide.
   localparam int MAX_FLOORS = 7;

   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   localparam logic OPEN  = 1'b1;
   localparam logic CLOSE = 1'b0;
   localparam logic MOVE  = 1'b1;
   localparam logic HOLD  = 1'b0;
   localparam logic ON    = 1'b1;
   localparam logic OFF   = 1'b0;

   typedef enum logic [1:0] {
      IDLE,
      MOVING,
      DOOR_OPEN,
      DECIDE
   } state_t;

   // Hall bus layout: bit 2*(f-1) is UP at floor f, the next bit is DOWN at f.
   function automatic int hall_idx(input int floor, input logic down);
      return 2 * (floor - 1) + (down ? 1 : 0);
   endfunction

   // UP <-> DOWN; only called while the car has a travel direction.
   function automatic logic [1:0] flip_dir(input logic [1:0] dir);
      return {dir[0], dir[1]};
   endfunction

endpackage

// File: rtl/request_scan.sv
// Purpose : combinational view of pending calls relative to one floor and direction.
// Latency : zero (pure combinational).
// Backpressure: none; requests are level inputs owned by the button-latch block.
// Ports   : floor_i/dir_i select the reference point; floor_button_i/internal_button_i are
//           the latched hall and cab calls; outputs flag calls at this floor, above, below,
//           ahead of and behind the given direction.
module request_scan
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = 7
) (
   input  logic [2:0]  floor_i,
   input  logic [1:0]  dir_i,
   input  logic [13:0] floor_button_i,
   input  logic [9:1]  internal_button_i,
   output logic        here_up_o,
   output logic        here_dn_o,
   output logic        here_cab_o,
   output logic        any_above_o,
   output logic        any_below_o,
   output logic        ahead_o,
   output logic        behind_o
);

   logic [MAX_FLOORS:1] calls;

   // Cab buttons 8 and 9 exist on the panel but never correspond to a served floor.
   logic unused_cab_hi;
   assign unused_cab_hi = ^internal_button_i[9:8];

   // Any kind of call per served floor; floors beyond NUM_FLOORS stay zero.
   always_comb begin
      calls = '0;
      for (int f = 1; f <= MAX_FLOORS; f++) begin
         if (f <= NUM_FLOORS) begin
            calls[f] = floor_button_i[hall_idx(f, 1'b0)]
                     | floor_button_i[hall_idx(f, 1'b1)]
                     | internal_button_i[f];
         end
      end
   end

   always_comb begin
      here_up_o   = 1'b0;
      here_dn_o   = 1'b0;
      here_cab_o  = 1'b0;
      any_above_o = 1'b0;
      any_below_o = 1'b0;
      for (int f = 1; f <= MAX_FLOORS; f++) begin
         if (f <= NUM_FLOORS) begin
            if (f == int'(floor_i)) begin
               here_up_o  = floor_button_i[hall_idx(f, 1'b0)];
               here_dn_o  = floor_button_i[hall_idx(f, 1'b1)];
               here_cab_o = internal_button_i[f];
            end
            if (f > int'(floor_i)) any_above_o = any_above_o | calls[f];
            if (f < int'(floor_i)) any_below_o = any_below_o | calls[f];
         end
      end
   end

   // With no direction both are 0; the floor limits fall out naturally because
   // nothing exists above the top floor or below floor 1.
   assign ahead_o  = ((dir_i == DIR_UP) & any_above_o) | ((dir_i == DIR_DOWN) & any_below_o);
   assign behind_o = ((dir_i == DIR_UP) & any_below_o) | ((dir_i == DIR_DOWN) & any_above_o);

endmodule

// File: rtl/car_controller.sv
// Purpose : SCAN (collective) motion/door controller for a 2-way elevator car.
// Latency : every decision is registered and visible one enabled cycle after its inputs.
// Backpressure: enable=0 freezes all state; requests are level inputs, never stalled.
// Ports   : clk/reset (sync, active-high), enable; floor_button (hall UP/DOWN pairs),
//           internal_button (cab [9:1]); current_floor (1-based), current_direction
//           ([0]=UP,[1]=DOWN), door_state (1=open), move (1=travelling).
module car_controller
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS  = 7,
   parameter int FLOOR_TICKS = 50,
   parameter int DOOR_TICKS  = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [13:0] floor_button,
   input  logic [9:1]  internal_button,
   output logic [2:0]  current_floor,
   output logic [1:0]  current_direction,
   output logic        door_state,
   output logic        move
);

   localparam int MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
   localparam int TW        = $clog2(MAX_TICKS);
   localparam logic [TW-1:0] FLOOR_LAST = TW'(FLOOR_TICKS - 1);
   localparam logic [TW-1:0] DOOR_LAST  = TW'(DOOR_TICKS - 1);

   state_t        state_q;
   logic [2:0]    floor_q;
   logic [1:0]    dir_q;
   logic          door_q;
   logic          move_q;
   logic [TW-1:0] timer_q;

   logic [2:0]    next_floor_d;

   // Scan at the floor the car is standing on.
   logic here_up, here_dn, here_cab, any_above, any_below, ahead, behind;
   // Scan at the floor the car arrives at when the travel timer wraps.
   logic arr_up, arr_dn, arr_cab, arr_ahead;
   logic arr_unused_above, arr_unused_below, arr_unused_behind;

   // One floor along the travel direction, clamped to the served range.
   always_comb begin
      next_floor_d = floor_q;
      if (dir_q == DIR_UP && floor_q < 3'(NUM_FLOORS)) begin
         next_floor_d = floor_q + 3'd1;
      end else if (dir_q == DIR_DOWN && floor_q > 3'd1) begin
         next_floor_d = floor_q - 3'd1;
      end
   end

   request_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan_here (
      .floor_i           (floor_q),
      .dir_i             (dir_q),
      .floor_button_i    (floor_button),
      .internal_button_i (internal_button),
      .here_up_o         (here_up),
      .here_dn_o         (here_dn),
      .here_cab_o        (here_cab),
      .any_above_o       (any_above),
      .any_below_o       (any_below),
      .ahead_o           (ahead),
      .behind_o          (behind)
   );

   request_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan_next (
      .floor_i           (next_floor_d),
      .dir_i             (dir_q),
      .floor_button_i    (floor_button),
      .internal_button_i (internal_button),
      .here_up_o         (arr_up),
      .here_dn_o         (arr_dn),
      .here_cab_o        (arr_cab),
      .any_above_o       (arr_unused_above),
      .any_below_o       (arr_unused_below),
      .ahead_o           (arr_ahead),
      .behind_o          (arr_unused_behind)
   );

   // Hall calls at the arrival floor split by travel direction.
   logic arr_same, arr_opp, arr_stop, arr_flip, opp_here;
   assign arr_same = (dir_q == DIR_UP) ? arr_up : arr_dn;
   assign arr_opp  = (dir_q == DIR_UP) ? arr_dn : arr_up;
   assign arr_stop = arr_cab | arr_same | ~arr_ahead;
   // Turn around on arrival only when the opposite hall call is the reason to stop
   // at the end of the sweep; a same-direction call here keeps the direction.
   assign arr_flip = ~arr_ahead & arr_opp & ~arr_same;
   assign opp_here = (dir_q == DIR_UP) ? here_dn : here_up;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         floor_q <= 3'd1;
         dir_q   <= DIR_IDLE;
         door_q  <= CLOSE;
         move_q  <= HOLD;
         timer_q <= '0;
      end else if (enable == ON) begin
         case (state_q)
            IDLE: begin
               if (here_up | here_cab) begin
                  dir_q   <= DIR_UP;
                  door_q  <= OPEN;
                  timer_q <= '0;
                  state_q <= DOOR_OPEN;
               end else if (here_dn) begin
                  dir_q   <= DIR_DOWN;
                  door_q  <= OPEN;
                  timer_q <= '0;
                  state_q <= DOOR_OPEN;
               end else if (any_above) begin
                  dir_q   <= DIR_UP;
                  move_q  <= MOVE;
                  timer_q <= '0;
                  state_q <= MOVING;
               end else if (any_below) begin
                  dir_q   <= DIR_DOWN;
                  move_q  <= MOVE;
                  timer_q <= '0;
                  state_q <= MOVING;
               end
            end

            MOVING: begin
               if (timer_q == FLOOR_LAST) begin
                  timer_q <= '0;
                  floor_q <= next_floor_d;
                  if (arr_stop) begin
                     move_q  <= HOLD;
                     door_q  <= OPEN;
                     state_q <= DOOR_OPEN;
                     if (arr_flip) dir_q <= flip_dir(dir_q);
                  end
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end

            // Direction is held so the button block clears the matching hall bit.
            DOOR_OPEN: begin
               if (timer_q == DOOR_LAST) begin
                  timer_q <= '0;
                  door_q  <= CLOSE;
                  state_q <= DECIDE;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end

            DECIDE: begin
               if (ahead) begin
                  move_q  <= MOVE;
                  timer_q <= '0;
                  state_q <= MOVING;
               end else if (opp_here) begin
                  dir_q   <= flip_dir(dir_q);
                  door_q  <= OPEN;
                  timer_q <= '0;
                  state_q <= DOOR_OPEN;
               end else if (behind) begin
                  dir_q   <= flip_dir(dir_q);
                  move_q  <= MOVE;
                  timer_q <= '0;
                  state_q <= MOVING;
               end else begin
                  dir_q   <= DIR_IDLE;
                  state_q <= IDLE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign current_floor     = floor_q;
   assign current_direction = dir_q;
   assign door_state        = door_q;
   assign move              = move_q;

endmodule

// File: tb/tb_car_controller.sv
// Bench for car_controller with short travel/door times.
// A floor-level behavioural model (signed direction, countdown of remaining ticks)
// is compared against the outputs every cycle; directed scenarios add literal checks.
module tb_car_controller;

   localparam int NF = 7;
   localparam int FT = 4;
   localparam int DT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [13:0] fb;
   logic [9:1]  ib;
   logic [2:0]  current_floor;
   logic [1:0]  current_direction;
   logic        door_state;
   logic        move;

   always #5 clk = ~clk;

   car_controller #(.NUM_FLOORS(NF), .FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
      .clk               (clk),
      .reset             (reset),
      .enable            (enable),
      .floor_button      (fb),
      .internal_button   (ib),
      .current_floor     (current_floor),
      .current_direction (current_direction),
      .door_state        (door_state),
      .move              (move)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   bit chk_on       = 1'b0;

   // ---------------- behavioural model ----------------
   int m_floor = 1;
   int m_dir   = 0;   // +1 up, -1 down, 0 no direction
   int m_left  = 0;   // enabled ticks left in the current travel/door phase
   bit m_door  = 1'b0;
   bit m_move  = 1'b0;

   function automatic bit cab_at(input int f);
      if (f < 1 || f > NF) return 1'b0;
      return ib[f];
   endfunction
   function automatic bit up_at(input int f);
      if (f < 1 || f > NF) return 1'b0;
      return fb[2*f-2];
   endfunction
   function automatic bit dn_at(input int f);
      if (f < 1 || f > NF) return 1'b0;
      return fb[2*f-1];
   endfunction
   function automatic bit call_at(input int f);
      return cab_at(f) | up_at(f) | dn_at(f);
   endfunction
   function automatic bit calls_toward(input int f, input int d);
      if (d == 0) return 1'b0;
      for (int g = f + d; g >= 1 && g <= NF; g += d)
         if (call_at(g)) return 1'b1;
      return 1'b0;
   endfunction
   function automatic bit same_at(input int f, input int d);
      return (d > 0) ? up_at(f) : dn_at(f);
   endfunction
   function automatic bit opp_at(input int f, input int d);
      return (d > 0) ? dn_at(f) : up_at(f);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_floor = 1; m_dir = 0; m_left = 0; m_door = 1'b0; m_move = 1'b0;
      end else if (enable) begin
         if (m_move) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_floor = m_floor + m_dir;
               if (cab_at(m_floor) || same_at(m_floor, m_dir) || !calls_toward(m_floor, m_dir)) begin
                  if (!calls_toward(m_floor, m_dir) && opp_at(m_floor, m_dir) && !same_at(m_floor, m_dir))
                     m_dir = -m_dir;
                  m_move = 1'b0; m_door = 1'b1; m_left = DT;
               end else begin
                  m_left = FT;
               end
            end
         end else if (m_door) begin
            m_left = m_left - 1;
            if (m_left == 0) m_door = 1'b0;
         end else if (m_dir != 0) begin
            if (calls_toward(m_floor, m_dir)) begin
               m_move = 1'b1; m_left = FT;
            end else if (opp_at(m_floor, m_dir)) begin
               m_dir = -m_dir; m_door = 1'b1; m_left = DT;
            end else if (calls_toward(m_floor, -m_dir)) begin
               m_dir = -m_dir; m_move = 1'b1; m_left = FT;
            end else begin
               m_dir = 0;
            end
         end else begin
            if (up_at(m_floor) || cab_at(m_floor)) begin
               m_dir = 1; m_door = 1'b1; m_left = DT;
            end else if (dn_at(m_floor)) begin
               m_dir = -1; m_door = 1'b1; m_left = DT;
            end else if (calls_toward(m_floor, 1)) begin
               m_dir = 1; m_move = 1'b1; m_left = FT;
            end else if (calls_toward(m_floor, -1)) begin
               m_dir = -1; m_move = 1'b1; m_left = FT;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_on) begin
         logic [6:0] act;
         logic [6:0] exp;
         act = {current_floor, current_direction, door_state, move};
         exp = {3'(m_floor), (m_dir > 0) ? 2'b01 : (m_dir < 0) ? 2'b10 : 2'b00, m_door, m_move};
         tests_run++;
         if (act !== exp) begin
            tests_failed++;
            $display("FAIL model t=%0t got floor/dir/door/move=%b expected %b", $time, act, exp);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] outs();
      return {current_floor, current_direction, door_state, move};
   endfunction

   // One clock; afterwards emulate the button-latch block clearing serviced calls.
   task automatic tick();
      int f;
      @(posedge clk);
      #1;
      if (door_state === 1'b1) begin
         f = int'(current_floor);
         ib[f] = 1'b0;
         if (current_direction == 2'b01) fb[2*f-2] = 1'b0;
         if (current_direction == 2'b10) fb[2*f-1] = 1'b0;
      end
   endtask

   task automatic wait_door(input logic val, input int max_cycles, input string name);
      int n;
      n = 0;
      while (door_state !== val && n < max_cycles) begin
         tick();
         n++;
      end
      if (door_state !== val) begin
         tests_run++;
         tests_failed++;
         $display("FAIL %s: timeout door=%b expected %b", name, door_state, val);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int n;
      reset  = 1'b1;
      enable = 1'b1;
      fb     = '0;
      ib     = '0;
      tick();
      chk_on = 1'b1;
      tick();
      reset = 1'b0;

      // 1: idle with no calls
      for (int i = 0; i < 20; i++) begin
         tick();
         check("t1 idle", outs(), {3'd1, 2'b00, 1'b0, 1'b0});
      end

      // 2: cab 4 from floor 1
      ib[4] = 1'b1;
      tick();
      check("t2 start up", {current_direction, move}, {2'b01, 1'b1});
      n = 0;
      while (current_floor !== 3'd4 && n < 50) begin
         tick();
         n++;
      end
      check("t2 cycles to floor 4", n, 12);
      check("t2 door open at 4", {door_state, move}, {1'b1, 1'b0});
      tick();
      tick();
      check("t2 door open 3rd cycle", door_state, 1'b1);
      tick();
      check("t2 door closed", door_state, 1'b0);
      tick();
      check("t2 idle at 4", outs(), {3'd4, 2'b00, 1'b0, 1'b0});

      // 3: cab 3 + hall DOWN@5 from floor 1
      do_reset();
      fb[9] = 1'b1;
      ib[3] = 1'b1;
      wait_door(1'b1, 60, "t3 first stop");
      check("t3 stop at 3 going up", {current_floor, current_direction}, {3'd3, 2'b01});
      wait_door(1'b0, 20, "t3 leave 3");
      wait_door(1'b1, 60, "t3 second stop");
      check("t3 stop at 5 flipped", {current_floor, current_direction}, {3'd5, 2'b10});
      wait_door(1'b0, 20, "t3 close at 5");
      tick();
      check("t3 idle at 5", outs(), {3'd5, 2'b00, 1'b0, 1'b0});

      // 4: go to floor 3, then hall UP@3 while idle there
      ib[3] = 1'b1;
      wait_door(1'b1, 60, "t4 reach 3");
      check("t4 arrive 3 down", {current_floor, current_direction}, {3'd3, 2'b10});
      wait_door(1'b0, 20, "t4 close at 3");
      tick();
      check("t4 idle at 3", current_direction, 2'b00);
      fb[4] = 1'b1;
      tick();
      check("t4 hall up here opens", outs(), {3'd3, 2'b01, 1'b1, 1'b0});
      fb[4] = 1'b1;   // re-press while open in same direction
      tick();
      tick();
      check("t4 door still open", door_state, 1'b1);
      tick();
      check("t4 door not extended", door_state, 1'b0);
      tick();
      check("t4 back to idle", outs(), {3'd3, 2'b00, 1'b0, 1'b0});

      // 5: freeze mid-travel from 3 toward cab 6
      ib[6] = 1'b1;
      tick();
      check("t5 moving", {current_direction, move}, {2'b01, 1'b1});
      tick();
      tick();
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t5 frozen", outs(), {3'd3, 2'b01, 1'b0, 1'b1});
      end
      enable = 1'b1;
      tick();
      check("t5 one tick left", current_floor, 3'd3);
      tick();
      check("t5 reached 4", current_floor, 3'd4);
      wait_door(1'b1, 60, "t5 reach 6");
      check("t5 open at 6", {current_floor, current_direction, move}, {3'd6, 2'b01, 1'b0});

      // 6: reset while the door is open at 6
      tick();
      check("t6 door open", door_state, 1'b1);
      reset = 1'b1;
      tick();
      check("t6 reset values", outs(), {3'd1, 2'b00, 1'b0, 1'b0});
      reset = 1'b0;
      tick();
      check("t6 idle after reset", outs(), {3'd1, 2'b00, 1'b0, 1'b0});

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
